phase_selector_cal: RTL and testbench

- Parametrised oversampling phase selector for the deser400 receive path, with a built-in automatic phase calibrator.
- Each CLK400 cycle carries one data bit as W oversamples (serin).
- The block picks one of P=2W phases from {serin, previous serin} and outputs the sampled bit through a 3-stage pipeline.
- Phase source is either a manual register value or an edge-histogram calibration that centres the sample point between data transitions.

---
 rtl/phase_selector_pkg.sv | 31 +++
 rtl/phase_edge_histogram.sv | 46 ++++
 rtl/phase_selector_cal.sv | 143 ++++++++++++++
 tb/tb_phase_selector_cal.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/phase_selector_pkg.sv
// Shared types and sizing helpers for the oversampling phase selector and its
// edge-histogram calibrator.
package phase_selector_pkg;

  localparam int GRP = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ACCUM,
    S_SEARCH,
    S_APPLY
  } cal_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  function automatic int cnt_w(input int win_log2);
    return win_log2 + 1;
  endfunction

  function automatic int tot_w(input int win_log2, input int w);
    return win_log2 + clog2(w) + 1;
  endfunction

endpackage

// File: rtl/phase_edge_histogram.sv
// Per-position edge counters over one oversampled word plus a total edge count;
// all counters saturate and are cleared by reset or clr.
module phase_edge_histogram
  import phase_selector_pkg::*;
#(
  parameter int W        = 8,
  parameter int WIN_LOG2 = 10,
  parameter int CW       = cnt_w(WIN_LOG2),
  parameter int TW       = tot_w(WIN_LOG2, W)
) (
  input  logic                   CLK400,
  input  logic                   reset,
  input  logic                   clr,
  input  logic                   en,
  input  logic [W-1:0]           serin,
  input  logic [W-1:0]           serdel,
  output logic [W-1:0][CW-1:0]   cnt,
  output logic [TW-1:0]          total
);

  logic [W-1:0]  e;
  logic [TW-1:0] pc;
  logic [TW:0]   tsum;

  // Position 0 compares against the last sample of the previous word.
  assign e = serin ^ {serin[W-2:0], serdel[W-1]};

  always_comb begin
    pc = '0;
    for (int j = 0; j < W; j++) pc = pc + TW'(e[j]);
  end

  assign tsum = {1'b0, total} + {1'b0, pc};

  always_ff @(posedge CLK400) begin
    if (reset || clr) begin
      cnt   <= '0;
      total <= '0;
    end else if (en) begin
      for (int j = 0; j < W; j++)
        if (e[j] && (cnt[j] != {CW{1'b1}})) cnt[j] <= cnt[j] + 1'b1;
      total <= tsum[TW] ? {TW{1'b1}} : tsum[TW-1:0];
    end
  end

endmodule

// File: rtl/phase_selector_cal.sv
// Oversampling phase selector: picks one of 2W phases from {serin, serdel}
// through a 3-stage one-hot/OR pipeline, with histogram-based phase calibration.
module phase_selector_cal
  import phase_selector_pkg::*;
#(
  parameter int W          = 8,
  parameter int PSW        = clog2(2 * W),
  parameter int WIN_LOG2   = 10,
  parameter int MIN_EDGES  = 16,
  parameter int INIT_PHASE = W / 2
) (
  input  logic           CLK400,
  input  logic           reset,
  input  logic [W-1:0]   serin,
  input  logic           mode_auto,
  input  logic [PSW-1:0] phsel_man,
  input  logic           cal_start,
  output logic           serout,
  output logic [PSW-1:0] phsel_act,
  output logic           cal_busy,
  output logic           cal_done,
  output logic           cal_fail
);

  localparam int P  = 2 * W;
  localparam int NG = P / GRP;
  localparam int SW = clog2(W);
  localparam int CW = cnt_w(WIN_LOG2);
  localparam int TW = tot_w(WIN_LOG2, W);

  logic [W-1:0]         serdel;
  logic [P-1:0]         ser, pos, stage1;
  logic [NG-1:0]        stage2, grp_or;
  logic                 stage3;
  logic [PSW-1:0]       phsel_cal;

  cal_state_e           state;
  logic [WIN_LOG2-1:0]  win_cnt;
  logic [SW-1:0]        sidx, jmax;
  logic [CW-1:0]        best;
  logic [W-1:0][CW-1:0] cnt;
  logic [TW-1:0]        total;
  logic [PSW-1:0]       jsum, ph_next;

  assign ser = {serin, serdel};

  always_comb begin
    grp_or = '0;
    for (int g = 0; g < NG; g++) grp_or[g] = |stage1[g*GRP +: GRP];
  end

  // pos is a single registered one-hot, so a phase change never ORs two taps.
  always_ff @(posedge CLK400) begin
    if (reset) begin
      serdel    <= '0;
      phsel_act <= PSW'(INIT_PHASE);
      pos       <= '0;
      stage1    <= '0;
      stage2    <= '0;
      stage3    <= 1'b0;
    end else begin
      serdel    <= serin;
      phsel_act <= mode_auto ? phsel_cal : phsel_man;
      pos       <= {{(P-1){1'b0}}, 1'b1} << phsel_act;
      stage1    <= ser & pos;
      stage2    <= grp_or;
      stage3    <= |stage2;
    end
  end

  assign serout = stage3;

  phase_edge_histogram #(
    .W(W), .WIN_LOG2(WIN_LOG2), .CW(CW), .TW(TW)
  ) u_hist (
    .CLK400 (CLK400),
    .reset  (reset),
    .clr    (state == S_CLEAR),
    .en     (state == S_ACCUM),
    .serin  (serin),
    .serdel (serdel),
    .cnt    (cnt),
    .total  (total)
  );

  // Sample half a bit away from the most frequent edge position.
  assign jsum    = PSW'(jmax) + PSW'(W / 2);
  assign ph_next = (jsum >= PSW'(W)) ? jsum - PSW'(W) : jsum;

  always_ff @(posedge CLK400) begin
    if (reset) begin
      state     <= S_IDLE;
      win_cnt   <= '0;
      sidx      <= '0;
      jmax      <= '0;
      best      <= '0;
      phsel_cal <= PSW'(INIT_PHASE);
      cal_fail  <= 1'b0;
      cal_done  <= 1'b0;
    end else begin
      cal_done <= (state == S_APPLY);
      case (state)
        S_IDLE:
          if (cal_start) begin
            state    <= S_CLEAR;
            cal_fail <= 1'b0;
          end
        S_CLEAR: begin
          win_cnt <= '0;
          state   <= S_ACCUM;
        end
        S_ACCUM: begin
          win_cnt <= win_cnt + 1'b1;
          if (win_cnt == {WIN_LOG2{1'b1}}) begin
            sidx  <= '0;
            state <= S_SEARCH;
          end
        end
        S_SEARCH: begin
          if ((sidx == '0) || (cnt[sidx] > best)) begin
            best <= cnt[sidx];
            jmax <= sidx;
          end
          sidx <= sidx + 1'b1;
          if (sidx == SW'(W - 1)) state <= S_APPLY;
        end
        S_APPLY: begin
          if (total < TW'(MIN_EDGES)) begin
            cal_fail <= 1'b1;
          end else begin
            phsel_cal <= ph_next;
            cal_fail  <= 1'b0;
          end
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign cal_busy = (state != S_IDLE);

endmodule

// File: tb/tb_phase_selector_cal.sv
// Directed bench for phase_selector_cal (W=8): reset, manual sweep, calibration,
// failed calibration, tie-break/ignored start and glitch-free phase switch.
module tb_phase_selector_cal;

  localparam int W   = 8;
  localparam int PSW = 4;

  logic           CLK400 = 1'b0;
  logic           reset;
  logic [W-1:0]   serin;
  logic           mode_auto;
  logic [PSW-1:0] phsel_man;
  logic           cal_start;
  logic           serout;
  logic [PSW-1:0] phsel_act;
  logic           cal_busy, cal_done, cal_fail;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic [W-1:0] hist [8];

  always #5 CLK400 = ~CLK400;

  phase_selector_cal #(
    .W(W), .PSW(PSW), .WIN_LOG2(10), .MIN_EDGES(16), .INIT_PHASE(4)
  ) dut (
    .CLK400    (CLK400),
    .reset     (reset),
    .serin     (serin),
    .mode_auto (mode_auto),
    .phsel_man (phsel_man),
    .cal_start (cal_start),
    .serout    (serout),
    .phsel_act (phsel_act),
    .cal_busy  (cal_busy),
    .cal_done  (cal_done),
    .cal_fail  (cal_fail)
  );

  // Advance one cycle: outputs of the new cycle are stable, serin for it is applied.
  task automatic next(input logic [W-1:0] s);
    @(posedge CLK400);
    #1;
    cyc++;
    serin = s;
    hist[cyc % 8] = s;
  endtask

  // Reference sample: phase p of ser in cycle c, from the recorded input words.
  function automatic logic ser_bit(input int c, input int p);
    logic [W-1:0] wv;
    if (p >= W) begin
      wv = hist[c % 8];
      return wv[p - W];
    end
    wv = hist[(c - 1) % 8];
    return wv[p];
  endfunction

  task automatic run_cal(input logic [W-1:0] a, input logic [W-1:0] b,
                         input int poke_at, output int blen, output int dones);
    logic ph;
    ph = 1'b0;
    cal_start = 1'b1;
    next(a);
    cal_start = 1'b0;
    blen  = 0;
    dones = 0;
    while (cal_busy && blen < 3000) begin
      blen++;
      if (cal_done) dones++;
      cal_start = (blen == poke_at);
      ph = ~ph;
      next(ph ? b : a);
    end
    cal_start = 1'b0;
  endtask

  task automatic test_reset();
    int dn;
    reset = 1'b1; mode_auto = 1'b0; cal_start = 1'b0; phsel_man = '0; serin = '0;
    for (int i = 0; i < 3; i++) begin
      next(W'($urandom));
      checks++;
      if (serout !== 1'b0) begin errors++; $display("FAIL reset_serout: got %b want 0", serout); end
    end
    checks += 4;
    if (phsel_act !== 4'd4) begin errors++; $display("FAIL reset_phsel: got %0d want 4", phsel_act); end
    if (cal_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", cal_busy); end
    if (cal_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", cal_done); end
    if (cal_fail !== 1'b0) begin errors++; $display("FAIL reset_fail: got %b want 0", cal_fail); end
    reset = 1'b0;
    next(8'h00);
    // Abort a calibration part-way through its accumulation window.
    mode_auto = 1'b1;
    cal_start = 1'b1;
    next(8'h00);
    cal_start = 1'b0;
    checks++;
    if (cal_busy !== 1'b1) begin errors++; $display("FAIL abort_busy_start: got %b want 1", cal_busy); end
    repeat (100) next(8'h00);
    reset = 1'b1;
    next(8'h00);
    reset = 1'b0;
    checks++;
    if (cal_busy !== 1'b0) begin errors++; $display("FAIL abort_busy_drop: got %b want 0", cal_busy); end
    dn = 0;
    repeat (20) begin
      next(8'h00);
      if (cal_done) dn++;
    end
    checks++;
    if (dn != 0) begin errors++; $display("FAIL abort_no_done: got %0d pulses want 0", dn); end
  endtask

  task automatic test_no_data();
    int blen, dones;
    mode_auto = 1'b1;
    run_cal(8'h00, 8'h00, 0, blen, dones);
    checks += 5;
    if (blen != 1034) begin errors++; $display("FAIL nodata_busy_len: got %0d want 1034", blen); end
    if (dones != 0) begin errors++; $display("FAIL nodata_early_done: got %0d want 0", dones); end
    if (cal_done !== 1'b1) begin errors++; $display("FAIL nodata_done: got %b want 1", cal_done); end
    if (cal_fail !== 1'b1) begin errors++; $display("FAIL nodata_fail: got %b want 1", cal_fail); end
    if (phsel_act !== 4'd4) begin errors++; $display("FAIL nodata_phsel_at_done: got %0d want 4", phsel_act); end
    next(8'h00);
    checks += 2;
    if (phsel_act !== 4'd4) begin errors++; $display("FAIL nodata_phsel: got %0d want 4", phsel_act); end
    if (cal_done !== 1'b0) begin errors++; $display("FAIL nodata_done_width: got %b want 0", cal_done); end
  endtask

  task automatic test_manual_sweep();
    mode_auto = 1'b0;
    for (int p = 0; p < 2 * W; p++) begin
      phsel_man = PSW'(p);
      repeat (5) next((cyc % 2) ? 8'h07 : 8'hF8);
      repeat (3) begin
        next((cyc % 2) ? 8'h07 : 8'hF8);
        checks++;
        if (serout !== ser_bit(cyc - 3, p)) begin
          errors++;
          $display("FAIL sweep_phase%0d: got %b want %b", p, serout, ser_bit(cyc - 3, p));
        end
      end
    end
  endtask

  task automatic test_calibrate();
    int blen, dones;
    mode_auto = 1'b1;
    run_cal(8'hF8, 8'h07, 0, blen, dones);
    checks += 4;
    if (blen != 1034) begin errors++; $display("FAIL cal_busy_len: got %0d want 1034", blen); end
    if (dones != 0) begin errors++; $display("FAIL cal_early_done: got %0d want 0", dones); end
    if (cal_done !== 1'b1) begin errors++; $display("FAIL cal_done: got %b want 1", cal_done); end
    if (cal_fail !== 1'b0) begin errors++; $display("FAIL cal_fail: got %b want 0", cal_fail); end
    next((cyc % 2) ? 8'h07 : 8'hF8);
    checks += 2;
    if (phsel_act !== 4'd7) begin errors++; $display("FAIL cal_phsel: got %0d want 7", phsel_act); end
    if (cal_done !== 1'b0) begin errors++; $display("FAIL cal_done_width: got %b want 0", cal_done); end
    repeat (4) next((cyc % 2) ? 8'h07 : 8'hF8);
    repeat (2) begin
      next((cyc % 2) ? 8'h07 : 8'hF8);
      checks++;
      if (serout !== ser_bit(cyc - 3, 7)) begin
        errors++;
        $display("FAIL cal_serout: got %b want %b", serout, ser_bit(cyc - 3, 7));
      end
    end
  endtask

  task automatic test_tie_ignore();
    int blen, dones, late;
    mode_auto = 1'b1;
    run_cal(8'h1C, 8'h1C, 100, blen, dones);
    checks += 4;
    if (blen != 1034) begin errors++; $display("FAIL tie_busy_len: got %0d want 1034", blen); end
    if (dones != 0) begin errors++; $display("FAIL tie_early_done: got %0d want 0", dones); end
    if (cal_done !== 1'b1) begin errors++; $display("FAIL tie_done: got %b want 1", cal_done); end
    if (cal_fail !== 1'b0) begin errors++; $display("FAIL tie_fail: got %b want 0", cal_fail); end
    late = 0;
    next(8'h1C);
    checks++;
    if (phsel_act !== 4'd6) begin errors++; $display("FAIL tie_phsel: got %0d want 6", phsel_act); end
    repeat (20) begin
      if (cal_done || cal_busy) late++;
      next(8'h1C);
    end
    checks++;
    if (late != 0) begin errors++; $display("FAIL tie_extra_cal: got %0d busy/done cycles want 0", late); end
  endtask

  task automatic test_phase_switch();
    logic exp;
    mode_auto = 1'b0;
    phsel_man = 4'd0;
    repeat (8) next(8'h80);
    checks++;
    if (serout !== 1'b0) begin errors++; $display("FAIL switch_before: got %b want 0", serout); end
    phsel_man = 4'd15;
    for (int k = 1; k <= 7; k++) begin
      next(8'h80);
      exp = (k >= 5);
      checks++;
      if (serout !== exp) begin errors++; $display("FAIL switch_cycle%0d: got %b want %b", k, serout, exp); end
      if (k == 1) begin
        checks++;
        if (phsel_act !== 4'd15) begin errors++; $display("FAIL switch_phsel: got %0d want 15", phsel_act); end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) hist[i] = '0;
    test_reset();
    test_no_data();
    test_manual_sweep();
    test_calibrate();
    test_tie_ignore();
    test_phase_switch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
